// File: rtl/cache_sa_wb.sv
// Set-associative write-back line cache with true-LRU replacement,
// per-line dirty bits, a victim eviction port and a whole-array flush engine.
module cache_sa_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int SETS       = 256,
  parameter int WAYS       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  evict_valid,
  output logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [DATA_WIDTH-1:0] evict_data,
  input  logic                  flush_req,
  output logic                  flush_done
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;

  // Valid/dirty/age are reset; tag and data arrays are not.
  logic [SETS-1:0][WAYS-1:0]            valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;
  logic [TAG_W-1:0]      tag_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit, accept, flast;
  logic [AGE_W-1:0] hit_way, vic_way, acc_way, acc_age;
  logic [IDX_W-1:0] fset_q;
  logic [AGE_W-1:0] fway_q;

  assign idx       = req_addr[IDX_W-1:0];
  assign tag       = req_addr[ADDR_WIDTH-1:IDX_W];
  assign req_ready = (state_q == IDLE) && !flush_req && reset_n;
  assign accept    = req_valid && req_ready;
  assign flast     = (fset_q == IDX_W'(SETS-1)) && (fway_q == AGE_W'(WAYS-1));

  // Tag lookup and victim choice: lowest invalid way wins, else the oldest way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS-1)) vic_way = AGE_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[idx][w]) vic_way = AGE_W'(w);
    end
    acc_way = hit ? hit_way : vic_way;
    acc_age = age_q[idx][acc_way];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: flush_req only matters in IDLE; leave FLUSH after the last line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (flast)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush scan pointer walks set-major, way-minor; parked at zero outside FLUSH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fset_q <= '0;
      fway_q <= '0;
    end else if (state_q == FLUSH) begin
      if (fway_q == AGE_W'(WAYS-1)) begin
        fway_q <= '0;
        fset_q <= fset_q + 1'b1;
      end else begin
        fway_q <= fway_q + 1'b1;
      end
    end else begin
      fset_q <= '0;
      fway_q <= '0;
    end
  end

  // Line state: flush clears one line per cycle; hits and write-allocates touch LRU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else if (state_q == FLUSH) begin
      valid_q[fset_q][fway_q] <= 1'b0;
      dirty_q[fset_q][fway_q] <= 1'b0;
      age_q[fset_q][fway_q]   <= fway_q;
    end else if (accept && (hit || req_write)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == acc_way)         age_q[idx][w] <= '0;
        else if (age_q[idx][w] < acc_age) age_q[idx][w] <= age_q[idx][w] + AGE_W'(1);
      end
      if (req_write) begin
        valid_q[idx][acc_way] <= 1'b1;
        dirty_q[idx][acc_way] <= 1'b1;
      end
    end
  end

  // Tag/data write on write hit or write-allocate.
  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      data_q[idx][acc_way] <= req_wdata;
      tag_q[idx][acc_way]  <= tag;
    end
  end

  // Registered response, eviction and flush-done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_rdata  <= '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_data  <= '0;
      flush_done  <= 1'b0;
    end else begin
      resp_valid  <= accept;
      resp_hit    <= accept && hit;
      resp_rdata  <= (accept && hit && !req_write) ? data_q[idx][hit_way] : '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_data  <= '0;
      flush_done  <= (state_q == FLUSH) && flast;
      if (state_q == FLUSH) begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          evict_valid <= 1'b1;
          evict_addr  <= {tag_q[fset_q][fway_q], fset_q};
          evict_data  <= data_q[fset_q][fway_q];
        end
      end else if (accept && req_write && !hit &&
                   valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
        evict_valid <= 1'b1;
        evict_addr  <= {tag_q[idx][vic_way], idx};
        evict_data  <= data_q[idx][vic_way];
      end
    end
  end
endmodule

// File: tb/tb_cache_sa_wb.sv
// Randomized scoreboard bench for cache_sa_wb. The reference model keeps
// per-slot lines with last-use timestamps; the LRU victim is the oldest stamp.
module tb_cache_sa_wb;
  localparam int AW = 32, DW = 128, SETS = 256, WAYS = 4, IDX_W = 8, TAG_W = AW - IDX_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_hit;
  logic [DW-1:0] resp_rdata;
  logic          evict_valid;
  logic [AW-1:0] evict_addr;
  logic [DW-1:0] evict_data;
  logic          flush_req, flush_done;

  always #5 clk = ~clk;

  cache_sa_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  typedef struct packed { logic hit; logic [DW-1:0] data; } resp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;
  resp_t resp_q[$];
  ev_t   ev_q[$];

  int n_cmp = 0, n_bad = 0, done_seen = 0, exp_done = 0, ev_seen = 0;
  logic [AW-1:0] last_ev_addr = '0;

  bit               m_valid [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  logic [DW-1:0]    m_data  [SETS][WAYS];
  longint           m_use   [SETS][WAYS];
  longint           tick = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: hit check, MRU stamp, write-allocate into lowest empty slot or LRU line.
  task automatic model_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s, hw, v;
    logic [TAG_W-1:0] t;
    longint oldest;
    resp_t r;
    ev_t e;
    s = int'(a[IDX_W-1:0]);
    t = a[AW-1:IDX_W];
    hw = -1;
    tick++;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    r.hit = 1'b0;
    r.data = '0;
    if (hw >= 0) begin
      r.hit = 1'b1;
      m_use[s][hw] = tick;
      if (wr) begin
        m_data[s][hw] = d;
        m_dirty[s][hw] = 1'b1;
      end else begin
        r.data = m_data[s][hw];
      end
    end else if (wr) begin
      v = -1;
      for (int w = 0; w < WAYS; w++)
        if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) begin
        oldest = 64'h7fff_ffff_ffff_ffff;
        for (int w = 0; w < WAYS; w++)
          if (m_use[s][w] < oldest) begin
            oldest = m_use[s][w];
            v = w;
          end
        if (m_dirty[s][v]) begin
          e.addr = {m_tag[s][v], IDX_W'(s)};
          e.data = m_data[s][v];
          ev_q.push_back(e);
        end
      end
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_data[s][v]  = d;
      m_use[s][v]   = tick;
    end
    resp_q.push_back(r);
  endtask

  // Reference flush: every dirty line leaves in set-then-slot order; all lines drop.
  task automatic model_flush();
    ev_t e;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (m_valid[s][w] && m_dirty[s][w]) begin
          e.addr = {m_tag[s][w], IDX_W'(s)};
          e.data = m_data[s][w];
          ev_q.push_back(e);
        end
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; flush_req = 1'b0;
    #1 chk("req_ready_idle", DW'(req_ready), DW'(1));
    model_access(wr, a, d);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic flush_run();
    int lo;
    @(negedge clk);
    req_valid = 1'b0; flush_req = 1'b1;
    #1 chk("req_ready_flush_req", DW'(req_ready), DW'(0));
    model_flush();
    @(negedge clk);
    flush_req = 1'b0;
    lo = 0;
    #1;
    while (!req_ready && lo < 4*SETS*WAYS) begin
      lo++;
      @(negedge clk);
      #1;
    end
    chk("flush_busy_cycles", DW'(lo), DW'(SETS*WAYS));
    exp_done++;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or eviction.
  resp_t mr;
  ev_t   me;
  always @(negedge clk) begin
    if (reset_n) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) chk("resp_unexpected", DW'(1), DW'(0));
        else begin
          mr = resp_q.pop_front();
          chk("resp_hit", DW'(resp_hit), DW'(mr.hit));
          chk("resp_rdata", resp_rdata, mr.data);
        end
      end else begin
        chk("resp_idle_hit", DW'(resp_hit), DW'(0));
        chk("resp_idle_rdata", resp_rdata, '0);
      end
      if (evict_valid) begin
        ev_seen++;
        last_ev_addr = evict_addr;
        if (ev_q.size() == 0) chk("evict_unexpected", DW'(evict_addr), DW'(0));
        else begin
          me = ev_q.pop_front();
          chk("evict_addr", DW'(evict_addr), DW'(me.addr));
          chk("evict_data", evict_data, me.data);
        end
      end
      if (flush_done) done_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lo_cnt, ev0, r;
    logic [7:0] ix;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; flush_req = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_use[s][w] = 0;
      end
    #12;
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("rst_evict_valid", DW'(evict_valid), DW'(0));
    chk("rst_flush_done", DW'(flush_done), DW'(0));
    #10 reset_n = 1'b1;

    // Cold read miss, then write-allocate and read-after-write hit.
    issue(0, 32'h105, '0);
    idle();
    issue(1, 32'h105, {16{8'hA5}});
    issue(0, 32'h105, '0);
    idle();

    // Fill set 5 and overflow it: LRU victim is 0x105.
    issue(1, 32'h205, rnd_data());
    issue(1, 32'h305, rnd_data());
    issue(1, 32'h405, rnd_data());
    issue(1, 32'h505, rnd_data());
    idle();
    repeat (2) @(negedge clk);
    chk("lru_victim_first", DW'(last_ev_addr), DW'(32'h105));

    // Touching 0x105 before the overflow shifts the victim to 0x205.
    flush_run();
    issue(1, 32'h105, rnd_data());
    issue(1, 32'h205, rnd_data());
    issue(1, 32'h305, rnd_data());
    issue(1, 32'h405, rnd_data());
    issue(0, 32'h105, '0);
    issue(1, 32'h505, rnd_data());
    idle();
    repeat (2) @(negedge clk);
    chk("lru_victim_after_touch", DW'(last_ev_addr), DW'(32'h205));

    // Flush with exactly two dirty lines.
    flush_run();
    issue(1, 32'h010, rnd_data());
    issue(1, 32'h3FF, rnd_data());
    idle();
    repeat (2) @(negedge clk);
    ev0 = ev_seen;
    flush_run();
    repeat (2) @(negedge clk);
    chk("flush_two_evicts", DW'(ev_seen - ev0), DW'(2));
    chk("flush_last_evict", DW'(last_ev_addr), DW'(32'h3FF));
    issue(0, 32'h010, '0);
    idle();

    // Reset 100 cycles into a flush: 0x005 already written back, 0x2FF never.
    issue(1, 32'h005, rnd_data());
    issue(1, 32'h2FF, rnd_data());
    idle();
    @(negedge clk);
    flush_req = 1'b1;
    model_flush();
    @(negedge clk);
    flush_req = 1'b0;
    repeat (99) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_resp_valid", DW'(resp_valid), DW'(0));
    chk("abort_evict_valid", DW'(evict_valid), DW'(0));
    chk("abort_flush_done", DW'(flush_done), DW'(0));
    chk("abort_req_ready", DW'(req_ready), DW'(0));
    chk("abort_pending_evicts", DW'(ev_q.size()), DW'(1));
    ev_q.delete();
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    issue(0, 32'h2FF, '0);
    issue(0, 32'h005, '0);
    idle();

    // Randomized traffic concentrated on a few sets with a small tag pool.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) flush_run();
      else if (r < 12) idle();
      else begin
        case ($urandom_range(0, 3))
          0: ix = 8'h05;
          1: ix = 8'h10;
          2: ix = 8'hFF;
          default: ix = 8'($urandom_range(0, 255));
        endcase
        issue(bit'($urandom_range(0, 1)), {24'($urandom_range(0, 5)), ix}, rnd_data());
      end
    end
    idle();
    lo_cnt = 0;
    while ((resp_q.size() != 0 || ev_q.size() != 0) && lo_cnt < 20) begin
      lo_cnt++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("resp_queue_drained", DW'(resp_q.size()), DW'(0));
    chk("evict_queue_drained", DW'(ev_q.size()), DW'(0));
    chk("flush_done_count", DW'(done_seen), DW'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised set-associative, write-back successor to the direct-mapped line cache.
- Configurable sets and ways with true-LRU replacement and per-line dirty bits.
- Dirty victims leave through an eviction port. A flush engine writes back and invalidates the whole array.
- Sits between the request master and the line-write buffer. Addresses are line addresses: one DATA_WIDTH word per line.

Parameters:
- ADDR_WIDTH, 32: line-address width.
- DATA_WIDTH, 128: line width in bits.
- SETS, 256: number of sets; power of 2, at least 2.
- WAYS, 4: associativity; power of 2, 1..8.
- Derived: IDX_W = log2(SETS), TAG_W = ADDR_WIDTH - IDX_W, AGE_W = max(1, log2(WAYS)).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  cache can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  line address; index = [IDX_W-1:0], tag = upper TAG_W bits.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  lookup hit.
- resp_rdata  out  DATA_WIDTH  read data on read hit, else 0.
- evict_valid  out  1  one-cycle pulse: dirty line written back.
- evict_addr  out  ADDR_WIDTH  full line address of the victim, {tag, index}.
- evict_data  out  DATA_WIDTH  victim data.
- flush_req  in  1  start write-back plus invalidate of all lines.
- flush_done  out  1  one-cycle pulse at flush completion.

Behaviour:
- Reset (async, reset_n=0):
  - All valid and dirty bits cleared.
  - Way w of every set gets age w.
  - FSM goes to IDLE.
  - All outputs 0. req_ready is 0 while reset_n=0.
  - Data and tag arrays are not reset.
- FSM has two states, IDLE and FLUSH.
- req_ready = (state==IDLE) && !flush_req && reset_n.
- A request is accepted on a rising edge with req_valid && req_ready. All array, age and dirty updates happen at that edge.
- Response timing: resp_valid=1 exactly in the cycle after acceptance, registered. resp_hit and resp_rdata are valid only while resp_valid=1 and are 0 otherwise.
- Hit: some way in the indexed set has valid && tag match. At most one way may match.
- Read hit: resp_hit=1, resp_rdata = line data, accessed way becomes MRU.
- Read miss: resp_hit=0, resp_rdata=0, no allocation, ages unchanged.
- Write hit: data overwritten, dirty=1, way becomes MRU, resp_hit=1, resp_rdata=0.
- Write miss (write-allocate):
  - Victim selection: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
  - If the victim is valid and dirty, evict_valid/evict_addr/evict_data pulse in the response cycle carrying the old contents.
  - Victim is filled with valid=1, dirty=1, new tag and data, and becomes MRU.
  - resp_hit=0.
- LRU update: the accessed way's age goes to 0. Every way whose age was below the accessed way's old age increments. Ages remain a permutation of 0..WAYS-1.
- Back-to-back requests are allowed every cycle. A read in the cycle after a write to the same address hits and returns the new data.
- Flush entry: flush_req=1 in IDLE moves the FSM to FLUSH at the next edge. No request is accepted in that cycle. flush_req is ignored in FLUSH.
- Flush operation:
  - Scans set 0..SETS-1, way 0..WAYS-1, one line per cycle (SETS*WAYS cycles).
  - Each valid && dirty line is presented on the evict port for one cycle (evict_valid pulse, registered one cycle after it is scanned); clean lines produce no pulse.
  - Every line is cleared to valid=0, dirty=0.
  - Ages are reset to age w for way w.
- Flush completion: after the last line, flush_done pulses one cycle (aligned with the last line's evict slot) and the FSM returns to IDLE.
- A response pending from the request accepted in the flush_req cycle-1 still issues normally.
- Reset mid-flush: abort immediately, all lines invalid, no further evict pulses and no flush_done.
- Evict addresses are always the full {tag, index}.

Test Plan:
- Reset, then read 0x0000_0105 -> resp_valid=1 one cycle later, resp_hit=0, resp_rdata=0; evict_valid stays 0.
- Write 0x105 data 0xA5 (x16 bytes), then read 0x105 the next cycle -> first response resp_hit=0 (allocate), second response resp_hit=1 with rdata=0xA5A5..A5.
- WAYS=4: write 0x105, 0x205, 0x305, 0x405, then 0x505 (all set 0x05) -> fifth response resp_hit=0, evict_valid=1, evict_addr=0x105, evict_data = data written to 0x105.
- As above, but read 0x105 before writing 0x505 -> 0x105 becomes MRU, so the eviction is 0x205 instead.
- Dirty lines at 0x010 and 0x3FF (SETS=256, WAYS=4), then flush_req -> req_ready=0 for 1024 cycles, exactly two evict pulses (0x010 then 0x3FF), flush_done once; a later read of 0x010 gives resp_hit=0.
- Deassert reset_n 100 cycles into a flush -> outputs 0 immediately; after release, no flush_done; a read of a previously valid line misses; req_ready returns to 1.
